universal_shift_register: RTL
=============================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1): width of the shift counter.
REQ-003 clk  input  1  rising-edge clock; all state changes on it.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  operation enable; 0 = hold all state.
REQ-006 mode  input  3  operation select (encoding in Function).
REQ-007 d0  input  1  serial input; enters bit 0 on shift-left.
REQ-008 d1  input  1  serial input; enters bit WIDTH-1 on shift-right.
REQ-009 pd  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents, registered.
REQ-011 so  output  1  last bit shifted or rotated out, registered.
REQ-012 cnt  output  CW  shift operations since last load/clear/reset, registered.
REQ-013 full  output  1  combinational; 1 when cnt == WIDTH.

Function
REQ-014 Operation takes effect on the rising clk edge with en=1; new q is visible one cycle after sampling (latency 1).
REQ-015 mode 000 hold: q, so and cnt unchanged.
REQ-016 mode 001 shift right: q <= {d1, q[WIDTH-1:1]}; so <= old q[0].
REQ-017 mode 010 shift left: q <= {q[WIDTH-2:0], d0}; so <= old q[WIDTH-1].
REQ-018 mode 011 parallel load: q <= pd; so unchanged; cnt <= 0.
REQ-019 mode 100 rotate right: q <= {q[0], q[WIDTH-1:1]}; so <= old q[0].
REQ-020 mode 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; so <= old q[WIDTH-1].
REQ-021 mode 110 arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}; so <= old q[0].
REQ-022 mode 111 clear: q <= 0; so <= 0; cnt <= 0.
REQ-023 Modes 001, 010, 100, 101, 110 with en=1 increment cnt by 1.
REQ-024 cnt saturates at WIDTH; further shifts leave cnt = WIDTH and full = 1.
REQ-025 en=0 holds q, so and cnt regardless of mode, d0, d1 and pd.
REQ-026 Serial inputs, pd and mode are sampled only at the active edge; no combinational path from any input to q, so or cnt.

Reset
REQ-027 rst=1 at a rising edge forces q=0, so=0 and cnt=0 (full=0), overriding en and mode.
REQ-028 rst asserted mid-sequence discards the operation of that cycle.
REQ-029 Normal operation resumes on the first edge with rst=0.
REQ-030 Before the first reset edge, outputs are undefined and are not checked.

Configuration
REQ-031 Macro USR_ROTATE_EN defined: modes 100 and 101 rotate per REQ-019/REQ-020.
REQ-032 USR_ROTATE_EN undefined: modes 100 and 101 behave exactly as mode 000 (q, so and cnt unchanged); rotate logic is absent.

Verification (WIDTH=4, USR_ROTATE_EN defined unless stated)
REQ-033 Reset, then load pd=1011, then shift-left with d0=0 -> q=0110, so=1, cnt=1.
REQ-034 From q=1000, shift-right four times with d1=1 -> q=1111; cnt=4, full=1; fifth shift -> cnt stays 4.
REQ-035 From q=1001: rotate right -> 1100, so=1; rotate left -> 1001, so=1; arithmetic shift right from 1001 -> 1100.
REQ-036 q=0101, en=0 with mode=010 for 3 cycles -> q, so and cnt unchanged; then clear -> q=0000, so=0, cnt=0.
REQ-037 rst=1 in the same cycle as load pd=1111 with en=1 -> q=0000, cnt=0 after the edge.
REQ-038 Build without USR_ROTATE_EN: q=1001 with mode=100 -> q=1001, cnt unchanged.

Source files
------------

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - universal shift register with load, clear, shifts and saturating shift counter
// Optional rotate modes (100/101) are built only when USR_ROTATE_EN is defined.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             d0,
  input  logic             d1,
  input  logic [WIDTH-1:0] pd,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_inc;

  assign full    = (cnt == CNT_MAX);
  // Counter stops at WIDTH so it reports "fully shifted" instead of wrapping.
  assign cnt_inc = full ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      so  <= 1'b0;
      cnt <= '0;
    end else if (en) begin
      case (mode)
        3'b001: begin
          q   <= {d1, q[WIDTH-1:1]};
          so  <= q[0];
          cnt <= cnt_inc;
        end
        3'b010: begin
          q   <= {q[WIDTH-2:0], d0};
          so  <= q[WIDTH-1];
          cnt <= cnt_inc;
        end
        3'b011: begin
          q   <= pd;
          cnt <= '0;
        end
`ifdef USR_ROTATE_EN
        3'b100: begin
          q   <= {q[0], q[WIDTH-1:1]};
          so  <= q[0];
          cnt <= cnt_inc;
        end
        3'b101: begin
          q   <= {q[WIDTH-2:0], q[WIDTH-1]};
          so  <= q[WIDTH-1];
          cnt <= cnt_inc;
        end
`endif
        3'b110: begin
          q   <= {q[WIDTH-1], q[WIDTH-1:1]};
          so  <= q[0];
          cnt <= cnt_inc;
        end
        3'b111: begin
          q   <= '0;
          so  <= 1'b0;
          cnt <= '0;
        end
        default: begin
          q   <= q;
          so  <= so;
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
